// File: rtl/hbuf_pg_ring_if.sv
// Page-ring bookkeeper bus: writer/readout handshakes, ring configuration and status.
interface hbuf_pg_ring_if #(
  parameter int PG_W   = 16,
  parameter int LOSS_W = 16
);
  logic              en;
  logic [PG_W-1:0]   start_pg;
  logic [PG_W-1:0]   stop_pg;
  logic [PG_W:0]     hwm_thresh;
  logic              wr_commit;
  logic              wr_busy;
  logic [PG_W-1:0]   pg_clr_cnt;
  logic              pg_clr_req;
  logic              pg_clr_ack;
  logic              flush_req;
  logic              flush_ack;
  logic [PG_W-1:0]   first_pg;
  logic [PG_W-1:0]   last_pg;
  logic [PG_W-1:0]   wr_pg_num;
  logic [PG_W-1:0]   rd_pg_num;
  logic [PG_W:0]     n_used_pgs;
  logic              empty;
  logic              full;
  logic              hwm;
  logic              buffered_data;
  logic [LOSS_W-1:0] drop_cnt;
  logic [LOSS_W-1:0] ovw_cnt;
  logic              cfg_err;

  // Writer / readout / slow-control side
  modport master (
    output en, start_pg, stop_pg, hwm_thresh, wr_commit, wr_busy,
           pg_clr_cnt, pg_clr_req, flush_req,
    input  pg_clr_ack, flush_ack, first_pg, last_pg, wr_pg_num, rd_pg_num,
           n_used_pgs, empty, full, hwm, buffered_data, drop_cnt, ovw_cnt, cfg_err
  );

  // Ring bookkeeper side
  modport slave (
    input  en, start_pg, stop_pg, hwm_thresh, wr_commit, wr_busy,
           pg_clr_cnt, pg_clr_req, flush_req,
    output pg_clr_ack, flush_ack, first_pg, last_pg, wr_pg_num, rd_pg_num,
           n_used_pgs, empty, full, hwm, buffered_data, drop_cnt, ovw_cnt, cfg_err
  );
endinterface

// File: rtl/hbuf_pg_ring.sv
// Page-ring bookkeeper for the DDR3 hit buffer: circular write/read page pointers
// over [first_pg, last_pg], occupancy, clear/flush handshakes, overflow policy,
// high-water flag and saturating loss counters.
module hbuf_pg_ring #(
  parameter int PG_W      = 16,
  parameter int OVERWRITE = 0,
  parameter int LOSS_W    = 16
) (
  input  logic          clk,
  input  logic          rst,
  hbuf_pg_ring_if.slave bus
);

  typedef enum logic [2:0] {
    S_OFF,
    S_RUN,
    S_CLR,
    S_FLUSH,
    S_ACK
  } state_t;

  state_t            state_q, state_d;
  logic              en_q, en_d;
  logic [PG_W-1:0]   first_q, first_d;
  logic [PG_W-1:0]   last_q, last_d;
  logic [PG_W:0]     span_q, span_d;
  logic [PG_W:0]     hwm_thr_q, hwm_thr_d;
  logic [PG_W-1:0]   wr_q, wr_d;
  logic [PG_W-1:0]   rd_q, rd_d;
  logic [PG_W:0]     n_used_q, n_used_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              hwm_q, hwm_d;
  logic              buf_q, buf_d;
  logic [LOSS_W-1:0] drop_q, drop_d;
  logic [LOSS_W-1:0] ovw_q, ovw_d;
  logic              cfg_err_q, cfg_err_d;
  logic              clr_ack_q, clr_ack_d;
  logic              flush_ack_q, flush_ack_d;
  logic              ack_held_q, ack_held_d;

  logic              en_rise;
  logic              upd_flags;
  logic [PG_W:0]     clr_k;
  logic [PG_W:0]     span_new;

  // Single-page advance with wrap at the upper ring bound
  function automatic logic [PG_W-1:0] adv1(input logic [PG_W-1:0] p,
                                           input logic [PG_W-1:0] lo,
                                           input logic [PG_W-1:0] hi);
    return (p == hi) ? lo : p + 1'b1;
  endfunction

  // Multi-page advance modulo span; k <= span and p in ring, so one subtract suffices
  function automatic logic [PG_W-1:0] adv_k(input logic [PG_W-1:0] p,
                                            input logic [PG_W:0]   k,
                                            input logic [PG_W-1:0] lo,
                                            input logic [PG_W:0]   span);
    logic [PG_W+1:0] sum;
    sum = {2'b00, p} - {2'b00, lo} + {1'b0, k};
    if (sum >= {1'b0, span}) sum = sum - {1'b0, span};
    return lo + sum[PG_W-1:0];
  endfunction

  // Next-state, pointer and counter update; clear, commit, flush applied in that order
  always_comb begin
    state_d     = state_q;
    en_d        = bus.en;
    first_d     = first_q;
    last_d      = last_q;
    span_d      = span_q;
    hwm_thr_d   = hwm_thr_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    n_used_d    = n_used_q;
    empty_d     = empty_q;
    full_d      = full_q;
    hwm_d       = hwm_q;
    buf_d       = buf_q;
    drop_d      = drop_q;
    ovw_d       = ovw_q;
    cfg_err_d   = cfg_err_q;
    clr_ack_d   = 1'b0;
    flush_ack_d = 1'b0;
    upd_flags   = 1'b0;

    en_rise  = bus.en & ~en_q;
    span_new = {1'b0, bus.stop_pg} - {1'b0, bus.start_pg} + 1'b1;
    clr_k    = ({1'b0, bus.pg_clr_cnt} < n_used_q) ? {1'b0, bus.pg_clr_cnt} : n_used_q;

    if (state_q == S_OFF) begin
      if (en_rise) begin
        first_d = bus.start_pg;
        last_d  = bus.stop_pg;
        if (bus.stop_pg < bus.start_pg) begin
          cfg_err_d = 1'b1;
        end else begin
          cfg_err_d = 1'b0;
          span_d    = span_new;
          hwm_thr_d = bus.hwm_thresh;
          rd_d      = bus.start_pg;
          wr_d      = bus.start_pg;
          n_used_d  = '0;
          drop_d    = '0;
          ovw_d     = '0;
          upd_flags = 1'b1;
          state_d   = S_RUN;
        end
      end else if (!ack_held_q) begin
        // Requests outstanding while disabled get one ack so readout never hangs
        if (bus.pg_clr_req)     clr_ack_d   = 1'b1;
        else if (bus.flush_req) flush_ack_d = 1'b1;
      end
    end else if (!bus.en) begin
      state_d = S_OFF;
    end else begin
      upd_flags = 1'b1;

      if (state_q == S_CLR) begin
        rd_d      = adv_k(rd_q, clr_k, first_q, span_q);
        n_used_d  = n_used_q - clr_k;
        clr_ack_d = 1'b1;
        state_d   = S_ACK;
      end

      // Commit is judged against the post-clear occupancy, giving n_used - k + 1
      if (bus.wr_commit) begin
        if (n_used_d != span_q) begin
          wr_d     = adv1(wr_q, first_q, last_q);
          n_used_d = n_used_d + 1'b1;
        end else if (OVERWRITE != 0) begin
          wr_d = adv1(wr_q, first_q, last_q);
          rd_d = adv1(rd_d, first_q, last_q);
          if (ovw_q != '1) ovw_d = ovw_q + 1'b1;
        end else begin
          if (drop_q != '1) drop_d = drop_q + 1'b1;
        end
      end

      if (state_q == S_FLUSH && !bus.wr_busy) begin
        rd_d        = wr_d;
        n_used_d    = '0;
        flush_ack_d = 1'b1;
        state_d     = S_ACK;
      end

      if (state_q == S_RUN) begin
        if (bus.pg_clr_req)     state_d = S_CLR;
        else if (bus.flush_req) state_d = S_FLUSH;
      end

      if (state_q == S_ACK && !bus.pg_clr_req && !bus.flush_req) state_d = S_RUN;
    end

    if (upd_flags) begin
      empty_d = (n_used_d == '0);
      full_d  = (n_used_d == span_d);
      hwm_d   = (n_used_d >= hwm_thr_d);
      buf_d   = (n_used_d != '0);
    end

    if (clr_ack_d || flush_ack_d)               ack_held_d = 1'b1;
    else if (!bus.pg_clr_req && !bus.flush_req) ack_held_d = 1'b0;
    else                                        ack_held_d = ack_held_q;
  end

  // State and bookkeeping registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_OFF;
      en_q        <= 1'b0;
      first_q     <= '0;
      last_q      <= '0;
      span_q      <= '0;
      hwm_thr_q   <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      n_used_q    <= '0;
      empty_q     <= 1'b0;
      full_q      <= 1'b0;
      hwm_q       <= 1'b0;
      buf_q       <= 1'b0;
      drop_q      <= '0;
      ovw_q       <= '0;
      cfg_err_q   <= 1'b0;
      clr_ack_q   <= 1'b0;
      flush_ack_q <= 1'b0;
      ack_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      first_q     <= first_d;
      last_q      <= last_d;
      span_q      <= span_d;
      hwm_thr_q   <= hwm_thr_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      n_used_q    <= n_used_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      hwm_q       <= hwm_d;
      buf_q       <= buf_d;
      drop_q      <= drop_d;
      ovw_q       <= ovw_d;
      cfg_err_q   <= cfg_err_d;
      clr_ack_q   <= clr_ack_d;
      flush_ack_q <= flush_ack_d;
      ack_held_q  <= ack_held_d;
    end
  end

  assign bus.pg_clr_ack    = clr_ack_q;
  assign bus.flush_ack     = flush_ack_q;
  assign bus.first_pg      = first_q;
  assign bus.last_pg       = last_q;
  assign bus.wr_pg_num     = wr_q;
  assign bus.rd_pg_num     = rd_q;
  assign bus.n_used_pgs    = n_used_q;
  assign bus.empty         = empty_q;
  assign bus.full          = full_q;
  assign bus.hwm           = hwm_q;
  assign bus.buffered_data = buf_q;
  assign bus.drop_cnt      = drop_q;
  assign bus.ovw_cnt       = ovw_q;
  assign bus.cfg_err       = cfg_err_q;

endmodule

// File: tb/tb_hbuf_pg_ring.sv
// Bench for hbuf_pg_ring: drop-newest and overwrite-oldest instances share stimulus;
// expected values are queued as stimulus is driven and checked after each step.
module tb_hbuf_pg_ring;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hbuf_pg_ring_if #(.PG_W(16), .LOSS_W(16)) bus0 ();
  hbuf_pg_ring_if #(.PG_W(16), .LOSS_W(16)) bus1 ();

  hbuf_pg_ring #(.PG_W(16), .OVERWRITE(0), .LOSS_W(16)) u_ring_drop (
    .clk(clk), .rst(rst), .bus(bus0));
  hbuf_pg_ring #(.PG_W(16), .OVERWRITE(1), .LOSS_W(16)) u_ring_ovw (
    .clk(clk), .rst(rst), .bus(bus1));

  assign bus1.en         = bus0.en;
  assign bus1.start_pg   = bus0.start_pg;
  assign bus1.stop_pg    = bus0.stop_pg;
  assign bus1.hwm_thresh = bus0.hwm_thresh;
  assign bus1.wr_commit  = bus0.wr_commit;
  assign bus1.wr_busy    = bus0.wr_busy;
  assign bus1.pg_clr_cnt = bus0.pg_clr_cnt;
  assign bus1.pg_clr_req = bus0.pg_clr_req;
  assign bus1.flush_req  = bus0.flush_req;

  always #5 clk = ~clk;

  typedef enum int unsigned {
    O0_WR, O0_RD, O0_N, O0_FULL, O0_EMPTY, O0_HWM, O0_DROP, O0_CFG, O0_BUF,
    O0_FIRST, O0_LAST, O0_CLRACK, O0_FLACK,
    O1_WR, O1_RD, O1_N, O1_FULL, O1_OVW
  } sel_e;

  typedef struct {
    string       tag;
    sel_e        sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] obs(input sel_e s);
    case (s)
      O0_WR:     return 32'(bus0.wr_pg_num);
      O0_RD:     return 32'(bus0.rd_pg_num);
      O0_N:      return 32'(bus0.n_used_pgs);
      O0_FULL:   return 32'(bus0.full);
      O0_EMPTY:  return 32'(bus0.empty);
      O0_HWM:    return 32'(bus0.hwm);
      O0_DROP:   return 32'(bus0.drop_cnt);
      O0_CFG:    return 32'(bus0.cfg_err);
      O0_BUF:    return 32'(bus0.buffered_data);
      O0_FIRST:  return 32'(bus0.first_pg);
      O0_LAST:   return 32'(bus0.last_pg);
      O0_CLRACK: return 32'(bus0.pg_clr_ack);
      O0_FLACK:  return 32'(bus0.flush_ack);
      O1_WR:     return 32'(bus1.wr_pg_num);
      O1_RD:     return 32'(bus1.rd_pg_num);
      O1_N:      return 32'(bus1.n_used_pgs);
      O1_FULL:   return 32'(bus1.full);
      O1_OVW:    return 32'(bus1.ovw_cnt);
      default:   return 32'hdead_beef;
    endcase
  endfunction

  task automatic push(input string tag, input sel_e sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, obs(e.sel), e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic commit_one();
    bus0.wr_commit = 1'b1;
    tick();
    bus0.wr_commit = 1'b0;
  endtask

  // Hold a clear request for 'hold' cycles, then release; returns acks seen
  task automatic do_clear(input logic [15:0] cnt, input int hold, output int acks);
    acks = 0;
    bus0.pg_clr_cnt = cnt;
    bus0.pg_clr_req = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (bus0.pg_clr_ack) acks++;
    end
    bus0.pg_clr_req = 1'b0;
    tick();
    if (bus0.pg_clr_ack) acks++;
    tick();
  endtask

  task automatic reenable(input logic [15:0] start, input logic [15:0] stop,
                          input logic [16:0] thr);
    bus0.en = 1'b0;
    tick();
    bus0.start_pg   = start;
    bus0.stop_pg    = stop;
    bus0.hwm_thresh = thr;
    bus0.en = 1'b1;
    tick();
  endtask

  initial begin
    int acks;
    int seen;
    int exp_wr;

    bus0.en = 1'b0; bus0.start_pg = '0; bus0.stop_pg = '0; bus0.hwm_thresh = '0;
    bus0.wr_commit = 1'b0; bus0.wr_busy = 1'b0; bus0.pg_clr_cnt = '0;
    bus0.pg_clr_req = 1'b0; bus0.flush_req = 1'b0;

    // Reset state
    tick(); tick();
    push("rst_wr", O0_WR, 0);      push("rst_rd", O0_RD, 0);
    push("rst_n", O0_N, 0);        push("rst_empty", O0_EMPTY, 0);
    push("rst_full", O0_FULL, 0);  push("rst_cfg", O0_CFG, 0);
    push("rst_clrack", O0_CLRACK, 0); push("rst_flack", O0_FLACK, 0);
    drain();
    rst = 1'b0;
    tick();

    // Enable ring 5..10, then fill it
    reenable(16'd5, 16'd10, 17'd7);
    push("en_wr", O0_WR, 5);      push("en_rd", O0_RD, 5);
    push("en_n", O0_N, 0);        push("en_empty", O0_EMPTY, 1);
    push("en_first", O0_FIRST, 5); push("en_last", O0_LAST, 10);
    drain();
    for (int i = 1; i <= 6; i++) begin
      commit_one();
      exp_wr = (i < 6) ? 5 + i : 5;
      push($sformatf("fill_wr%0d", i), O0_WR, exp_wr);
      push($sformatf("fill_n%0d", i), O0_N, i);
      drain();
    end
    push("fill_full", O0_FULL, 1); push("fill_rd", O0_RD, 5);
    push("fill_buf", O0_BUF, 1);   push("fill_hwm", O0_HWM, 0);
    push("ovw_full6", O1_FULL, 1); push("ovw_n6", O1_N, 6);
    push("ovw_wr6", O1_WR, 5);
    drain();

    // Commits while full: drop vs overwrite
    commit_one();
    push("drop_cnt1", O0_DROP, 1); push("drop_wr", O0_WR, 5); push("drop_n", O0_N, 6);
    push("ovw_cnt1", O1_OVW, 1);   push("ovw_rd7", O1_RD, 6); push("ovw_wr7", O1_WR, 6);
    drain();
    commit_one();
    push("drop_cnt2", O0_DROP, 2);
    push("ovw_n8", O1_N, 6); push("ovw_rd8", O1_RD, 7); push("ovw_wr8", O1_WR, 7);
    push("ovw_cnt2", O1_OVW, 2); push("ovw_full8", O1_FULL, 1);
    drain();

    // Page clear: partial, then oversize count saturating at occupancy
    reenable(16'd5, 16'd10, 17'd7);
    push("reen_drop", O0_DROP, 0); push("reen_n", O0_N, 0);
    drain();
    for (int i = 0; i < 4; i++) commit_one();
    push("c4_wr", O0_WR, 9); push("c4_n", O0_N, 4);
    drain();
    do_clear(16'd1, 5, acks);
    check_eq("clr1_acks", acks, 1);
    push("clr1_rd", O0_RD, 6); push("clr1_n", O0_N, 3);
    drain();
    do_clear(16'd1000, 5, acks);
    check_eq("clrbig_acks", acks, 1);
    push("clrbig_rd", O0_RD, 9); push("clrbig_n", O0_N, 0); push("clrbig_empty", O0_EMPTY, 1);
    drain();

    // Commit in the clear-apply cycle, request held 5 cycles
    for (int i = 0; i < 3; i++) commit_one();
    push("c3_n", O0_N, 3); push("c3_wr", O0_WR, 6);
    drain();
    bus0.pg_clr_cnt = 16'd2;
    bus0.pg_clr_req = 1'b1;
    acks = 0;
    tick();
    if (bus0.pg_clr_ack) acks++;
    bus0.wr_commit = 1'b1;
    tick();
    bus0.wr_commit = 1'b0;
    if (bus0.pg_clr_ack) acks++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus0.pg_clr_ack) acks++;
    end
    bus0.pg_clr_req = 1'b0;
    tick();
    if (bus0.pg_clr_ack) acks++;
    tick();
    check_eq("clrcm_acks", acks, 1);
    push("clrcm_n", O0_N, 2); push("clrcm_rd", O0_RD, 5); push("clrcm_wr", O0_WR, 7);
    drain();

    // Request while disabled: one ack, state held
    bus0.en = 1'b0;
    tick();
    do_clear(16'd1, 5, acks);
    check_eq("off_acks", acks, 1);
    push("off_n", O0_N, 2); push("off_rd", O0_RD, 5); push("off_wr", O0_WR, 7);
    drain();

    // Flush waits for writer idle
    reenable(16'd5, 16'd10, 17'd7);
    commit_one(); commit_one();
    push("pf_n", O0_N, 2); push("pf_wr", O0_WR, 7);
    drain();
    bus0.wr_busy   = 1'b1;
    bus0.flush_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus0.flush_ack) acks++;
    end
    check_eq("flush_busy_acks", acks, 0);
    bus0.wr_busy = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      tick();
      if (bus0.flush_ack) seen = 1;
    end
    check_eq("flush_ack_seen", seen, 1);
    bus0.flush_req = 1'b0;
    tick(); tick();
    push("flush_n", O0_N, 0); push("flush_rd", O0_RD, 7);
    push("flush_wr", O0_WR, 7); push("flush_empty", O0_EMPTY, 1);
    drain();

    // Inverted bounds: cfg_err, commits ignored
    reenable(16'd10, 16'd5, 17'd4);
    commit_one(); commit_one();
    push("cfg_err", O0_CFG, 1); push("cfg_wr", O0_WR, 7); push("cfg_n", O0_N, 0);
    drain();

    // High-water threshold on a valid ring
    reenable(16'd5, 16'd10, 17'd4);
    push("hwm_cfg", O0_CFG, 0); push("hwm_0", O0_HWM, 0);
    drain();
    for (int i = 0; i < 3; i++) commit_one();
    push("hwm_3", O0_HWM, 0);
    drain();
    commit_one();
    push("hwm_4", O0_HWM, 1); push("hwm_n4", O0_N, 4);
    drain();

    // Reset mid-operation
    rst = 1'b1;
    #2;
    push("mrst_n", O0_N, 0); push("mrst_wr", O0_WR, 0);
    push("mrst_hwm", O0_HWM, 0); push("mrst_empty", O0_EMPTY, 0);
    drain();
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
